// File: rtl/decode_pkg.sv
// Types and constants shared by the decode stage and its field decoder.
// dec_entry_t carries pc/imm at the widest supported XLEN; users keep the low XLEN bits.
package decode_pkg;

`include "processor_defines.sv"

  localparam int unsigned XLEN_MAX = 64;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [4:0] LB      = `LB;
  localparam logic [4:0] LH      = `LH;
  localparam logic [4:0] LW      = `LW;
  localparam logic [4:0] LBU     = `LBU;
  localparam logic [4:0] LHU     = `LHU;
  localparam logic [4:0] LD_NOP  = `LD_NOP;
  localparam logic [1:0] JAL     = `JAL;
  localparam logic [1:0] JALR    = `JALR;
  localparam logic [1:0] JMP_NOP = `JMP_NOP;

  typedef enum logic [1:0] {
    CL_OTHER = 2'd0,
    CL_LOAD  = 2'd1,
    CL_JAL   = 2'd2,
    CL_JALR  = 2'd3
  } inst_class_t;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [XLEN_MAX-1:0] imm;
    logic [4:0]          ld_control;
    logic [1:0]          jump_control;
    inst_class_t         cls;
    logic                illegal;
  } dec_entry_t;

  localparam dec_entry_t ENTRY_RST = '{
    pc:           '0,
    rd:           '0,
    rs1:          '0,
    imm:          '0,
    ld_control:   LD_NOP,
    jump_control: JMP_NOP,
    cls:          CL_OTHER,
    illegal:      1'b0
  };

endpackage

// File: rtl/decode_fields.sv
// Combinational decoder for load and jump instructions.
// Ports:
//   instr  in   32-bit raw instruction
//   pc     in   XLEN-bit PC of instr
//   entry  out  decoded entry (pc zero-extended, imm sign-extended to XLEN_MAX)
module decode_fields
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output dec_entry_t      entry
);

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [XLEN_MAX-1:0] imm_i;
  logic [XLEN_MAX-1:0] imm_j;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign imm_i  = {{52{instr[31]}}, instr[31:20]};
  assign imm_j  = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    entry    = ENTRY_RST;
    entry.pc = XLEN_MAX'(pc);
    entry.rd = instr[11:7];
    case (opcode)
      OP_LOAD: begin
        entry.cls = CL_LOAD;
        entry.rs1 = instr[19:15];
        entry.imm = imm_i;
        case (funct3)
          3'd0:    entry.ld_control = LB;
          3'd1:    entry.ld_control = LH;
          3'd2:    entry.ld_control = LW;
          3'd4:    entry.ld_control = LBU;
          3'd5:    entry.ld_control = LHU;
          default: entry.illegal    = 1'b1;
        endcase
      end
      OP_JAL: begin
        entry.cls          = CL_JAL;
        entry.imm          = imm_j;
        entry.jump_control = JAL;
      end
      OP_JALR: begin
        entry.cls = CL_JALR;
        entry.rs1 = instr[19:15];
        if (funct3 == 3'd0) begin
          entry.jump_control = JALR;
          entry.imm          = imm_i;
        end else begin
          entry.illegal = 1'b1;
        end
      end
      default: ;
    endcase
    // Illegal encodings must never write back.
    if (entry.illegal) entry.rd = '0;
  end

endmodule

// File: rtl/processor_defines.sv
// Shared control encodings for the load and jump units.
// LD_* values drive the load/store unit byte-lane and sign-extension control; the
// JMP_* values select the PC source in execute. The NOP encodings are all-zero.
`ifndef PROCESSOR_DEFINES_SV
`define PROCESSOR_DEFINES_SV

`define LB      5'b00001
`define LH      5'b00010
`define LW      5'b00100
`define LBU     5'b01000
`define LHU     5'b10000
`define LD_NOP  5'b00000

`define JAL     2'b01
`define JALR    2'b10
`define JMP_NOP 2'b00

`endif

// File: rtl/decode_stage.sv
// Registered decode stage: decodes load/jump instructions and buffers them in a small FIFO.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   in_valid/in_ready              fetch handshake; in_instr, in_pc instruction and its PC
//   flush                          drop all buffered entries and the incoming instruction
//   out_valid/out_ready            execute handshake; out_* fields are the FIFO head entry
//   illegal_count                  saturating count of accepted illegal instructions
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [XLEN-1:0]   out_imm,
  output logic [4:0]        out_ld_control,
  output logic [1:0]        out_jump_control,
  output logic [1:0]        out_class,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  illegal_count
);

  localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_BITS = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_BITS-1:0] FULL = CNT_BITS'(FIFO_DEPTH);

  dec_entry_t          dec_entry;
  dec_entry_t          mem_q [FIFO_DEPTH];
  dec_entry_t          head;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [CNT_W-1:0]    ill_cnt_q, ill_cnt_d;
  logic                push, pop;

  decode_fields #(
    .XLEN (XLEN)
  ) u_fields (
    .instr (in_instr),
    .pc    (in_pc),
    .entry (dec_entry)
  );

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ill_cnt_d = ill_cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Depth is a power of two, so pointer overflow is the modulo wrap.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_BITS'(1);
        2'b01:   count_d = count_q - CNT_BITS'(1);
        default: ;
      endcase
    end
    if (push && dec_entry.illegal && (ill_cnt_q != '1)) ill_cnt_d = ill_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ill_cnt_q <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= ENTRY_RST;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ill_cnt_q <= ill_cnt_d;
      if (push) mem_q[wr_ptr_q] <= dec_entry;
    end
  end

  assign head             = mem_q[rd_ptr_q];
  assign out_pc           = head.pc[XLEN-1:0];
  assign out_rd           = head.rd;
  assign out_rs1          = head.rs1;
  assign out_imm          = head.imm[XLEN-1:0];
  assign out_ld_control   = head.ld_control;
  assign out_jump_control = head.jump_control;
  assign out_class        = head.cls;
  assign out_illegal      = head.illegal;
  assign illegal_count    = ill_cnt_q;

  // Upper pc/imm bits are only meaningful when XLEN is the maximum width.
  logic unused_head;
  assign unused_head = ^{head.pc, head.imm};

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  import decode_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = 2 ** CNT_W - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic [XLEN-1:0]  in_pc = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_pc;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [XLEN-1:0]  out_imm;
  logic [4:0]       out_ld_control;
  logic [1:0]       out_jump_control;
  logic [1:0]       out_class;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_count;

  decode_stage #(
    .XLEN       (XLEN),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_instr         (in_instr),
    .in_pc            (in_pc),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pc           (out_pc),
    .out_rd           (out_rd),
    .out_rs1          (out_rs1),
    .out_imm          (out_imm),
    .out_ld_control   (out_ld_control),
    .out_jump_control (out_jump_control),
    .out_class        (out_class),
    .out_illegal      (out_illegal),
    .illegal_count    (illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] pc;
    int              rd;
    int              rs1;
    longint          imm;
    logic [4:0]      ld;
    logic [1:0]      jmp;
    logic [1:0]      cls;
    bit              ill;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_cnt  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference decode built from the field rules with integer arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    exp_t e;
    int   op, f3, i_imm, j_imm;
    op    = int'(ins[6:0]);
    f3    = int'(ins[14:12]);
    i_imm = int'(ins[31:20]);
    if (i_imm >= 2048) i_imm -= 4096;
    j_imm = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
            - int'(ins[31]) * 1048576;
    e.pc = pc; e.rd = int'(ins[11:7]); e.rs1 = 0; e.imm = 0;
    e.ld = LD_NOP; e.jmp = JMP_NOP; e.cls = CL_OTHER; e.ill = 1'b0;
    if (op == 'h03) begin
      e.cls = CL_LOAD; e.rs1 = int'(ins[19:15]); e.imm = i_imm;
      case (f3)
        0: e.ld = LB;
        1: e.ld = LH;
        2: e.ld = LW;
        4: e.ld = LBU;
        5: e.ld = LHU;
        default: e.ill = 1'b1;
      endcase
    end else if (op == 'h6f) begin
      e.cls = CL_JAL; e.imm = j_imm; e.jmp = JAL;
    end else if (op == 'h67) begin
      e.cls = CL_JALR; e.rs1 = int'(ins[19:15]);
      if (f3 == 0) begin e.jmp = JALR; e.imm = i_imm; end
      else e.ill = 1'b1;
    end
    if (e.ill) e.rd = 0;
    return e;
  endfunction

  // Check the current outputs against the model, then advance model and DUT one edge.
  task automatic step();
    exp_t            h;
    logic [XLEN-1:0] wimm;
    logic            acc, pop;
    check_eq("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
    check_eq("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check_eq("illegal_count", 64'(illegal_count), 64'(exp_cnt));
    if (q.size() != 0) begin
      h    = q[0];
      wimm = h.imm[XLEN-1:0];
      check_eq("head_pc", 64'(out_pc), 64'(h.pc));
      check_eq("head_rd", 64'(out_rd), 64'(h.rd));
      check_eq("head_rs1", 64'(out_rs1), 64'(h.rs1));
      check_eq("head_imm", 64'(out_imm), 64'(wimm));
      check_eq("head_ld", 64'(out_ld_control), 64'(h.ld));
      check_eq("head_jmp", 64'(out_jump_control), 64'(h.jmp));
      check_eq("head_class", 64'(out_class), 64'(h.cls));
      check_eq("head_illegal", 64'(out_illegal), 64'(h.ill));
    end
    if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() != DEPTH);
      pop = (q.size() != 0) && out_ready;
      if (pop) void'(q.pop_front());
      if (acc) begin
        h = ref_decode(in_instr, in_pc);
        q.push_back(h);
        if (h.ill && exp_cnt != CMAX) exp_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 3))
      0: r[6:0] = OP_LOAD;
      1: r[6:0] = OP_JAL;
      2: begin r[6:0] = OP_JALR; if ($urandom_range(0, 1) == 1) r[14:12] = 3'd0; end
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_pc", 64'(out_pc), 64'd0);
    check_eq("rst_imm", 64'(out_imm), 64'd0);
    check_eq("rst_rd", 64'(out_rd), 64'd0);
    check_eq("rst_ld", 64'(out_ld_control), 64'(LD_NOP));
    check_eq("rst_jmp", 64'(out_jump_control), 64'(JMP_NOP));
    check_eq("rst_class", 64'(out_class), 64'(CL_OTHER));
    check_eq("rst_count", 64'(illegal_count), 64'd0);
    reset = 1'b0;

    // Directed decodes, one in flight at a time.
    out_ready = 1'b1;
    push_one(32'h00812083, 32'h100);
    check_eq("lw_valid", 64'(out_valid), 64'd1);
    check_eq("lw_rd", 64'(out_rd), 64'd1);
    check_eq("lw_rs1", 64'(out_rs1), 64'd2);
    check_eq("lw_imm", 64'(out_imm), 64'd8);
    check_eq("lw_ld", 64'(out_ld_control), 64'(LW));
    check_eq("lw_class", 64'(out_class), 64'(CL_LOAD));
    step();
    push_one(32'hFF1FF0EF, 32'h104);
    check_eq("jal_imm", 64'(out_imm), 64'hFFFF_FFF0);
    check_eq("jal_rs1", 64'(out_rs1), 64'd0);
    check_eq("jal_jmp", 64'(out_jump_control), 64'(JAL));
    step();
    push_one(32'hFFC08067, 32'h108);
    check_eq("jalr_imm", 64'(out_imm), 64'hFFFF_FFFC);
    check_eq("jalr_jmp", 64'(out_jump_control), 64'(JALR));
    step();
    push_one(32'h0000B083, 32'h10C);
    check_eq("ill_ld_flag", 64'(out_illegal), 64'd1);
    check_eq("ill_ld_rd", 64'(out_rd), 64'd0);
    check_eq("ill_ld_ld", 64'(out_ld_control), 64'(LD_NOP));
    check_eq("ill_ld_count", 64'(illegal_count), 64'd1);
    step();
    push_one(32'h000090E7, 32'h110);
    check_eq("ill_jalr_flag", 64'(out_illegal), 64'd1);
    check_eq("ill_jalr_rd", 64'(out_rd), 64'd0);
    check_eq("ill_jalr_imm", 64'(out_imm), 64'd0);
    check_eq("ill_jalr_jmp", 64'(out_jump_control), 64'(JMP_NOP));
    step();

    // Backpressure: third push is held off, head stays put, then drain in order.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_instr = 32'h00012003 | (32'(i + 1) << 7);
      in_pc    = 32'h200 + 32'(4 * i);
      step();
    end
    check_eq("bp_in_ready", 64'(in_ready), 64'd0);
    check_eq("bp_head_pc", 64'(out_pc), 64'h200);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();

    // Flush with a full FIFO and a simultaneous incoming instruction.
    out_ready = 1'b0;
    push_one(32'h00412183, 32'h300);
    push_one(32'h00812203, 32'h304);
    in_valid = 1'b1; in_instr = 32'h00C12283; in_pc = 32'h308; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    check_eq("flush_out_valid", 64'(out_valid), 64'd0);
    check_eq("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) step();

    // Asynchronous reset between edges with two entries held.
    out_ready = 1'b0;
    push_one(32'h0000B083, 32'h400);
    push_one(32'h00812083, 32'h404);
    #2 reset = 1'b1;
    #1;
    check_eq("areset_out_valid", 64'(out_valid), 64'd0);
    check_eq("areset_in_ready", 64'(in_ready), 64'd1);
    check_eq("areset_count", 64'(illegal_count), 64'd0);
    q.delete();
    exp_cnt = 0;
    #1 reset = 1'b0;

    // Saturation of the illegal counter.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < CMAX + 3; i++) begin
      in_instr = 32'h0000F003 | (32'(i) << 20);
      in_pc    = 32'h500 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    step();
    check_eq("sat_count", 64'(illegal_count), 64'(CMAX));

    // Randomized traffic, model decides acceptance and ordering.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom();
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, flow-controlled instruction decode stage for load (I-type) and jump (JAL/JALR) instructions. It replaces the purely combinational load and jump decoders. Decode is parametrised in data width, and a small FIFO of decoded entries sits between fetch and execute. It adds sign-correct immediates, illegal-encoding detection, pipeline flush and an illegal-instruction counter.

## Interface
Parameters:
- XLEN, 32: datapath width; immediates and PC are XLEN bits. Legal values are 32 and 64.
- FIFO_DEPTH, 2: decoded-entry buffer depth; power of two, at least 2.
- CNT_W, 16: width of the illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts an instruction this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- flush  in  1  discard all buffered and incoming instructions.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes the head entry.
- out_pc  out  XLEN  PC of the head entry.
- out_rd  out  5  destination register.
- out_rs1  out  5  source register.
- out_imm  out  XLEN  sign-extended immediate.
- out_ld_control  out  5  one of `LB`, `LH`, `LW`, `LBU`, `LHU`, `LD_NOP`.
- out_jump_control  out  2  one of `JAL`, `JALR`, `JMP_NOP`.
- out_class  out  2  inst_class_t: CL_OTHER, CL_LOAD, CL_JAL, CL_JALR.
- out_illegal  out  1  the head entry has a reserved funct3.
- illegal_count  out  CNT_W  number of illegal instructions accepted; saturates at all-ones.

## Operation
- Decode is combinational on in_instr. The decoded entry is written into the FIFO on accept (in_valid && in_ready && !flush).
- LOAD (opcode 0000011):
  - funct3 0/1/2/4/5 maps to `LB`/`LH`/`LW`/`LBU`/`LHU`.
  - funct3 3/6/7 gives `LD_NOP` and illegal=1.
  - imm = sign-extend(instr[31:20]).
  - jump_control = `JMP_NOP`.
- JAL (opcode 1101111):
  - imm = sign-extend({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - rs1 = 0, `JAL`, ld_control = `LD_NOP`.
- JALR (opcode 1100111):
  - funct3 0 gives `JALR` with imm = sign-extend(instr[31:20]).
  - Any other funct3 gives `JMP_NOP`, imm = 0 and illegal=1.
- Any other opcode: CL_OTHER, `LD_NOP`, `JMP_NOP`, imm = 0, rs1 = 0, illegal=0.
- In all cases rd = instr[11:7], except that rd is forced to 0 when illegal=1, so no writeback occurs.
- FIFO:
  - Uses wr_ptr, rd_ptr and a count in the range 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
  - in_ready = (count != FIFO_DEPTH). There is no pass-through when full; a pop while full raises in_ready the next cycle.
  - Pop occurs on out_valid && out_ready. Simultaneous push and pop leaves count unchanged.
  - out_valid = (count != 0). The out_* fields show the head entry and are held stable while out_valid && !out_ready.
- flush:
  - Synchronous. The next state is count=0 with both pointers at 0.
  - An input arriving in the same cycle is dropped and not counted.
  - A pop in the same cycle is ignored.
- illegal_count increments on accept when illegal=1. It saturates at all-ones and is not cleared by flush.

## Timing
- Latency is one cycle: an instruction accepted at edge N appears at the head after edge N when the FIFO was empty.
- Throughput is one instruction per cycle while out_ready stays high.
- Reset values:
  - count=0, both pointers at 0, illegal_count=0.
  - out_valid=0, in_ready=1.
  - out_* data = 0, out_ld_control=`LD_NOP`, out_jump_control=`JMP_NOP`, out_class=CL_OTHER.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Data outputs are registered FIFO storage, with no combinational path from in_* to out_*.
- in_ready depends only on count, with no path from out_ready.

## Structure
- Package decode_pkg holds:
  - inst_class_t;
  - the opcode constants OP_LOAD, OP_JAL and OP_JALR;
  - the decoded-entry struct dec_entry_t (pc, rd, rs1, imm, ld_control, jump_control, class, illegal).
- The `LB`…`JMP_NOP` encodings remain in processor_defines.sv.
- One sub-module, decode_fields, is the combinational decoder: 32-bit instruction and PC in, dec_entry_t out, parametrised by XLEN.
- The FIFO is inlined in decode_stage.

## Test plan
- Reset, then in_instr=0x00812083 (lw x1,8(x2)) with out_ready=1 → next cycle out_valid=1, rd=1, rs1=2, imm=8, `LW`, CL_LOAD.
- JAL 0xFF1FF0EF (jal x1,-16) → imm = XLEN'(-16), rs1=0, `JAL`. JALR 0xFFC08067 (jalr x0,-4(x1)) → imm = XLEN'(-4), `JALR`.
- Load with funct3=3 (0x0000B083) → out_illegal=1, rd=0, `LD_NOP`, illegal_count=1. The JALR equivalent with funct3=1 also gives illegal=1.
- out_ready=0 with 3 pushes at FIFO_DEPTH=2 → in_ready=0 after 2 accepts and the head stays stable. Then out_ready=1 → entries drain in order, and in_ready=1 one cycle after the first pop.
- Full FIFO plus flush, with in_valid=1 in the same cycle → next cycle out_valid=0, in_ready=1, and the dropped instruction never appears.
- Assert reset asynchronously between edges with 2 entries held → out_valid=0 immediately; force illegal_count to 2^CNT_W−1 and push an illegal instruction → the count stays at all-ones.
